time_preset_ctrl: RTL and testbench
===================================

Name: time_preset_ctrl

Overview:
- Button-driven time-setting controller; the writer side of the counters' preset interface.
- Produces adjust, PE and the BCD preset values pre_hour, pre_min and pre_sec.
- These feed the hour, minute and second counters.
- Runs on the fast system clock. Holds PE long enough for the counters' slow clock to capture it.

Parameters:
- TIMEOUT_CYC, 10000, idle cycles in any edit state before the edit is aborted without commit.
- PE_HOLD, 4, number of CP cycles PE stays high during commit. Must be ≥1.
- TO_W, 14, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- CP  in  1  system clock.
- _CR  in  1  synchronous active-low reset.
- key_sel  in  1  debounced one-cycle pulse: enter edit / advance field.
- key_inc  in  1  debounced one-cycle pulse: increment selected field.
- key_ok  in  1  debounced one-cycle pulse: commit edit.
- mode12  in  1  1 = 12-hour format (01..12), 0 = 24-hour format (00..23).
- show_hour  in  8  current hour, packed BCD.
- show_min  in  8  current minute, packed BCD.
- show_sec  in  8  current second, packed BCD.
- adjust  out  1  high while editing or committing; freezes the counters.
- PE  out  1  preset enable to all three counters.
- pre_hour  out  8  BCD hour preset.
- pre_min  out  8  BCD minute preset.
- pre_sec  out  8  BCD second preset.
- edit_field  out  2  selected field: 0 none, 1 hour, 2 min, 3 sec (drives display blink).

Behaviour:
- Clock and reset: one clock, CP. Reset is synchronous and active-low, on _CR, sampled at the CP rising edge.
- Reset values: state IDLE; adjust=0; PE=0; pre_hour=pre_min=pre_sec=8'h00; edit_field=0; timeout counter 0.
- States: IDLE, E_HOUR, E_MIN, E_SEC, COMMIT.
- Outputs are registered. All outputs follow a state change in the same cycle the new state is entered.
- IDLE:
  - On key_sel: load show_* into pre_* and go to E_HOUR.
  - adjust rises in the cycle after the key_sel sample.
- Load sanitising: any field with a BCD digit >9, or a value above its maximum, loads as its minimum.
  - Maximum: 59 for min/sec; 23 for hour (mode12=0); 12 for hour (mode12=1).
  - Minimum: 00, except hour in 12-hour mode, which is 01.
- Edit states: adjust=1, PE=0, and edit_field encodes the state.
- Key priority when keys arrive in the same cycle: key_ok > key_sel > key_inc. Lower-priority keys are ignored.
- key_sel advances the field: E_HOUR → E_MIN → E_SEC → E_HOUR.
- key_inc increments the selected field in BCD, wrapping:
  - min/sec: 59 → 00.
  - hour, 24-hour: 23 → 00.
  - hour, 12-hour: 12 → 01.
- Low-digit carry: x9 → (x+1)0.
- key_ok goes to COMMIT. PE=1 and adjust=1 for exactly PE_HOLD cycles, with pre_* held stable; then IDLE with adjust=0, PE=0, edit_field=0.
- Timeout counter:
  - Cleared by any key press and on entering an edit state.
  - Increments every cycle in the edit states.
  - On reaching TIMEOUT_CYC: go to IDLE, adjust=0, no PE pulse. pre_* keep their last values.
- Keys are ignored in COMMIT. key_inc and key_ok are ignored in IDLE.
- mode12 changing mid-edit: the hour is re-sanitised at the next key_inc (wrap uses the current mode). No immediate correction is made.
- _CR low in any state (including mid-COMMIT): return to reset values next edge. PE drops immediately.
- pre_* change only on load or key_inc. They are never modified while PE=1.

Decomposition:
- Shared package clock_pkg holds:
  - state encoding;
  - edit_field codes;
  - BCD constants: SEC_MAX=8'h59, H24_MAX=8'h23, H12_MAX=8'h12, H12_MIN=8'h01.
- Sub-module bcd_inc_wrap, combinational:
  - inputs val[7:0], max[7:0], min[7:0];
  - output the next BCD value with wrap to min;
  - also exports a valid flag used by load sanitising.
- One instance of bcd_inc_wrap per field.

Test Plan:
1. _CR=0 for 2 cycles mid-edit → all outputs 0 and state IDLE next edge; a key_inc pulse afterwards → no change.
2. show=12:34:56, key_sel → E_HOUR, pre=12:34:56, adjust=1. Then key_sel ×2 → E_SEC. Then key_inc ×4 → pre_sec 56→57→58→59→00, pre_min stays 34.
3. mode12=0, hour 22, key_inc ×2 → 23 then 00. mode12=1, hour 12, key_inc → 01. hour 09, key_inc → 10.
4. key_ok from E_MIN, PE_HOLD=4 → PE high exactly 4 cycles with pre values constant and adjust=1, then adjust=0, PE=0, edit_field=0.
5. key_ok and key_inc in the same cycle → commit, no increment. key_sel and key_inc in the same cycle → field advances, no increment.
6. Edit state with no keys for TIMEOUT_CYC cycles → IDLE, adjust=0, PE never asserted. show_sec=8'h7A loaded → pre_sec=8'h00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting logic: controller states,
// edit_field codes and the packed-BCD limits of each time field.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E_HOUR = 3'd1,
    E_MIN  = 3'd2,
    E_SEC  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] H24_MAX  = 8'h23;
  localparam logic [7:0] H12_MAX  = 8'h12;
  localparam logic [7:0] H12_MIN  = 8'h01;
  localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/bcd_inc_wrap.sv
// Packed-BCD increment with wrap to a field minimum. Also flags whether the
// input is a legal value for the field, which the load path uses to sanitise.
module bcd_inc_wrap (
  input  logic [7:0] val,
  input  logic [7:0] max,
  input  logic [7:0] min,
  output logic [7:0] nxt,
  output logic       valid
);

  logic [3:0] hi;
  logic [3:0] lo;

  assign hi = val[7:4];
  assign lo = val[3:0];

  // Legal value check and next value; an illegal input wraps straight to min.
  always_comb begin
    valid = (hi <= 4'd9) && (lo <= 4'd9) && (val <= max) && (val >= min);
    if (!valid || (val == max)) begin
      nxt = min;
    end else if (lo == 4'd9) begin
      nxt = {hi + 4'd1, 4'd0};
    end else begin
      nxt = {hi, lo + 4'd1};
    end
  end

endmodule

// File: rtl/time_preset_ctrl.sv
// Button-driven time-setting controller. Captures the displayed time, lets
// the user step through and increment hour/minute/second, and on commit
// holds PE for PE_HOLD cycles so the slower counter clock can capture it.
module time_preset_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned PE_HOLD     = 4,
  parameter int unsigned TO_W        = 14
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_ok,
  input  logic       mode12,
  input  logic [7:0] show_hour,
  input  logic [7:0] show_min,
  input  logic [7:0] show_sec,
  output logic       adjust,
  output logic       PE,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic [1:0] edit_field
);

  localparam int unsigned HOLD_W = (PE_HOLD > 1) ? $clog2(PE_HOLD) : 1;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic [7:0] hr_max;
  logic [7:0] hr_min;
  logic [7:0] hr_src;
  logic [7:0] mn_src;
  logic [7:0] sc_src;
  logic [7:0] hr_nxt;
  logic [7:0] mn_nxt;
  logic [7:0] sc_nxt;
  logic       hr_ok;
  logic       mn_ok;
  logic       sc_ok;

  assign hr_max = mode12 ? H12_MAX : H24_MAX;
  assign hr_min = mode12 ? H12_MIN : BCD_ZERO;

  // In IDLE the checkers look at the displayed time (load sanitising);
  // while editing they look at the preset being edited (increment).
  assign hr_src = (state == IDLE) ? show_hour : pre_hour;
  assign mn_src = (state == IDLE) ? show_min  : pre_min;
  assign sc_src = (state == IDLE) ? show_sec  : pre_sec;

  bcd_inc_wrap u_hour (
    .val   (hr_src),
    .max   (hr_max),
    .min   (hr_min),
    .nxt   (hr_nxt),
    .valid (hr_ok)
  );

  bcd_inc_wrap u_min (
    .val   (mn_src),
    .max   (SEC_MAX),
    .min   (BCD_ZERO),
    .nxt   (mn_nxt),
    .valid (mn_ok)
  );

  bcd_inc_wrap u_sec (
    .val   (sc_src),
    .max   (SEC_MAX),
    .min   (BCD_ZERO),
    .nxt   (sc_nxt),
    .valid (sc_ok)
  );

  // Controller FSM with registered outputs, edit timeout and PE hold count.
  always_ff @(posedge CP) begin
    if (!_CR) begin
      state      <= IDLE;
      adjust     <= 1'b0;
      PE         <= 1'b0;
      pre_hour   <= '0;
      pre_min    <= '0;
      pre_sec    <= '0;
      edit_field <= FLD_NONE;
      to_cnt     <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          PE     <= 1'b0;
          to_cnt <= '0;
          if (key_sel) begin
            state      <= E_HOUR;
            adjust     <= 1'b1;
            edit_field <= FLD_HOUR;
            pre_hour   <= hr_ok ? show_hour : hr_min;
            pre_min    <= mn_ok ? show_min  : BCD_ZERO;
            pre_sec    <= sc_ok ? show_sec  : BCD_ZERO;
          end
        end

        E_HOUR, E_MIN, E_SEC: begin
          if (key_ok) begin
            state      <= COMMIT;
            PE         <= 1'b1;
            edit_field <= FLD_NONE;
            hold_cnt   <= '0;
            to_cnt     <= '0;
          end else if (key_sel) begin
            to_cnt <= '0;
            case (state)
              E_HOUR: begin
                state      <= E_MIN;
                edit_field <= FLD_MIN;
              end
              E_MIN: begin
                state      <= E_SEC;
                edit_field <= FLD_SEC;
              end
              default: begin
                state      <= E_HOUR;
                edit_field <= FLD_HOUR;
              end
            endcase
          end else if (key_inc) begin
            to_cnt <= '0;
            case (state)
              E_HOUR:  pre_hour <= hr_nxt;
              E_MIN:   pre_min  <= mn_nxt;
              default: pre_sec  <= sc_nxt;
            endcase
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state      <= IDLE;
            adjust     <= 1'b0;
            edit_field <= FLD_NONE;
            to_cnt     <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        COMMIT: begin
          if (hold_cnt == HOLD_W'(PE_HOLD - 1)) begin
            state  <= IDLE;
            PE     <= 1'b0;
            adjust <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          adjust     <= 1'b0;
          PE         <= 1'b0;
          edit_field <= FLD_NONE;
          to_cnt     <= '0;
          hold_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_preset_ctrl.sv
// Bench for time_preset_ctrl: directed scenarios followed by random key
// traffic, every cycle checked against a decimal-arithmetic model.
module tb_time_preset_ctrl;

  localparam int unsigned T_TO   = 40;
  localparam int unsigned T_HOLD = 4;

  logic       CP;
  logic       cr_n;
  logic       key_sel;
  logic       key_inc;
  logic       key_ok;
  logic       mode12;
  logic [7:0] show_hour;
  logic [7:0] show_min;
  logic [7:0] show_sec;
  logic       adjust;
  logic       PE;
  logic [7:0] pre_hour;
  logic [7:0] pre_min;
  logic [7:0] pre_sec;
  logic [1:0] edit_field;

  int tests_run = 0;
  int tests_failed = 0;

  // model state: field 0 = not editing, 1..3 = hour/min/sec
  int m_field;
  int m_commit;
  int m_idle;
  bit m_pe;
  int m_h;
  int m_m;
  int m_s;

  time_preset_ctrl #(
    .TIMEOUT_CYC (T_TO),
    .PE_HOLD     (T_HOLD),
    .TO_W        (6)
  ) dut (
    .CP         (CP),
    ._CR        (cr_n),
    .key_sel    (key_sel),
    .key_inc    (key_inc),
    .key_ok     (key_ok),
    .mode12     (mode12),
    .show_hour  (show_hour),
    .show_min   (show_min),
    .show_sec   (show_sec),
    .adjust     (adjust),
    .PE         (PE),
    .pre_hour   (pre_hour),
    .pre_min    (pre_min),
    .pre_sec    (pre_sec),
    .edit_field (edit_field)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic int bcd2int(input logic [7:0] b);
    int hi;
    int lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int sanitise(input int v, input int lo, input int hi);
    if (v < lo || v > hi) return lo;
    return v;
  endfunction

  function automatic int bump(input int v, input int lo, input int hi);
    if (v < lo || v >= hi) return lo;
    return v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model by one clock edge using the inputs about to be sampled
  task automatic model_edge(input bit rst_n, input bit sel, input bit inc, input bit ok);
    int hlo;
    int hhi;
    hlo = mode12 ? 1 : 0;
    hhi = mode12 ? 12 : 23;
    if (!rst_n) begin
      m_field = 0; m_commit = 0; m_idle = 0; m_pe = 0;
      m_h = 0; m_m = 0; m_s = 0;
    end else if (m_commit > 0) begin
      m_commit--;
      if (m_commit == 0) m_pe = 0;
    end else if (m_field == 0) begin
      if (sel) begin
        m_h = sanitise(bcd2int(show_hour), hlo, hhi);
        m_m = sanitise(bcd2int(show_min), 0, 59);
        m_s = sanitise(bcd2int(show_sec), 0, 59);
        m_field = 1;
        m_idle = 0;
      end
    end else begin
      if (ok) begin
        m_pe = 1;
        m_commit = T_HOLD;
        m_field = 0;
        m_idle = 0;
      end else if (sel) begin
        m_field = (m_field % 3) + 1;
        m_idle = 0;
      end else if (inc) begin
        if (m_field == 1) m_h = bump(m_h, hlo, hhi);
        else if (m_field == 2) m_m = bump(m_m, 0, 59);
        else m_s = bump(m_s, 0, 59);
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == int'(T_TO)) begin
          m_field = 0;
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".adjust"}, 32'(adjust), 32'((m_field != 0) || (m_commit > 0)));
    check({tag, ".PE"}, 32'(PE), 32'(m_pe));
    check({tag, ".edit_field"}, 32'(edit_field), 32'(m_field));
    check({tag, ".pre_hour"}, 32'(pre_hour), 32'(int2bcd(m_h)));
    check({tag, ".pre_min"}, 32'(pre_min), 32'(int2bcd(m_m)));
    check({tag, ".pre_sec"}, 32'(pre_sec), 32'(int2bcd(m_s)));
  endtask

  task automatic step(input string tag, input bit rst_n, input bit sel, input bit inc, input bit ok);
    cr_n = rst_n;
    key_sel = sel;
    key_inc = inc;
    key_ok = ok;
    model_edge(rst_n, sel, inc, ok);
    @(posedge CP);
    #1;
    cr_n = 1'b1;
    key_sel = 1'b0;
    key_inc = 1'b0;
    key_ok = 1'b0;
    check_all(tag);
  endtask

  task automatic finish_commit(input string tag);
    step(tag, 1, 0, 0, 1);
    for (int i = 0; i < int'(T_HOLD); i++) step(tag, 1, 0, 0, 0);
  endtask

  function automatic logic [7:0] rand_bcd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return int2bcd(int'($urandom_range(0, 59)));
  endfunction

  initial begin
    int pe_cycles;
    bit pe_seen;
    int rate;
    cr_n = 1'b0;
    key_sel = 1'b0;
    key_inc = 1'b0;
    key_ok = 1'b0;
    mode12 = 1'b0;
    show_hour = 8'h00;
    show_min = 8'h00;
    show_sec = 8'h00;
    m_field = 0; m_commit = 0; m_idle = 0; m_pe = 0;
    m_h = 0; m_m = 0; m_s = 0;

    // reset state
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    check("reset.adjust", 32'(adjust), 32'd0);

    // load 12:34:56, walk to seconds, increment through the wrap
    show_hour = 8'h12; show_min = 8'h34; show_sec = 8'h56;
    step("load", 1, 1, 0, 0);
    check("load.hour_const", 32'(pre_hour), 32'h12);
    check("load.adjust_const", 32'(adjust), 32'd1);
    step("sel_min", 1, 1, 0, 0);
    step("sel_sec", 1, 1, 0, 0);
    check("sel_sec.field_const", 32'(edit_field), 32'd3);
    for (int i = 0; i < 4; i++) step("inc_sec", 1, 0, 1, 0);
    check("sec_wrap_const", 32'(pre_sec), 32'h00);
    check("min_kept_const", 32'(pre_min), 32'h34);

    // reset mid-edit, then a stray key_inc in IDLE
    step("cr_mid0", 0, 0, 0, 0);
    step("cr_mid1", 0, 0, 0, 0);
    step("idle_inc", 1, 0, 1, 0);
    check("idle_inc.hour_const", 32'(pre_hour), 32'h00);

    // 24-hour wrap 22 -> 23 -> 00
    show_hour = 8'h22;
    step("h24_load", 1, 1, 0, 0);
    step("h24_inc", 1, 0, 1, 0);
    step("h24_inc", 1, 0, 1, 0);
    check("h24_wrap_const", 32'(pre_hour), 32'h00);
    finish_commit("h24_commit");

    // 12-hour wrap 12 -> 01, and digit carry 09 -> 10
    mode12 = 1'b1;
    show_hour = 8'h12;
    step("h12_load", 1, 1, 0, 0);
    step("h12_inc", 1, 0, 1, 0);
    check("h12_wrap_const", 32'(pre_hour), 32'h01);
    finish_commit("h12_commit");
    show_hour = 8'h09;
    step("carry_load", 1, 1, 0, 0);
    step("carry_inc", 1, 0, 1, 0);
    check("carry_const", 32'(pre_hour), 32'h10);

    // commit from E_MIN: PE high exactly T_HOLD cycles
    step("to_min", 1, 1, 0, 0);
    step("ok_min", 1, 0, 0, 1);
    pe_cycles = int'(PE);
    for (int i = 0; i < int'(T_HOLD) + 2; i++) begin
      step("pe_hold", 1, 0, 0, 0);
      pe_cycles += int'(PE);
    end
    check("pe_cycles", 32'(pe_cycles), 32'(T_HOLD));
    check("after_commit.field_const", 32'(edit_field), 32'd0);

    // simultaneous keys
    step("prio_load", 1, 1, 0, 0);
    step("ok_and_inc", 1, 0, 1, 1);
    check("ok_inc.hour_const", 32'(pre_hour), 32'h09);
    for (int i = 0; i < int'(T_HOLD); i++) step("prio_hold", 1, 0, 0, 0);
    step("prio_load2", 1, 1, 0, 0);
    step("sel_and_inc", 1, 1, 1, 0);
    check("sel_inc.field_const", 32'(edit_field), 32'd2);
    check("sel_inc.hour_const", 32'(pre_hour), 32'h09);
    finish_commit("prio_commit");

    // invalid second digit sanitised, then timeout without PE
    show_sec = 8'h7A;
    step("bad_sec_load", 1, 1, 0, 0);
    check("bad_sec_const", 32'(pre_sec), 32'h00);
    pe_seen = 1'b0;
    for (int i = 0; i < int'(T_TO) - 1; i++) begin
      step("to_wait", 1, 0, 0, 0);
      pe_seen |= PE;
    end
    check("to_before.adjust_const", 32'(adjust), 32'd1);
    step("to_expire", 1, 0, 0, 0);
    pe_seen |= PE;
    check("to_after.adjust_const", 32'(adjust), 32'd0);
    check("to_no_pe", 32'(pe_seen), 32'd0);

    // random traffic: busy keys first, then sparse keys so timeouts occur
    for (int phase = 0; phase < 2; phase++) begin
      rate = (phase == 0) ? 4 : 60;
      for (int i = 0; i < 1500; i++) begin
        bit r_rst;
        bit r_sel;
        bit r_inc;
        bit r_ok;
        if ($urandom_range(0, 49) == 0) mode12 = ~mode12;
        if ($urandom_range(0, 7) == 0) begin
          show_hour = rand_bcd();
          show_min = rand_bcd();
          show_sec = rand_bcd();
        end
        r_rst = ($urandom_range(0, 299) != 0);
        r_sel = ($urandom_range(0, rate * 2) == 0);
        r_inc = ($urandom_range(0, rate) == 0);
        r_ok = ($urandom_range(0, rate * 5) == 0);
        step("rand", r_rst, r_sel, r_inc, r_ok);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
